// File: rtl/tile_write_scheduler_if.sv
// Command and engine bus for the tile write scheduler.
// Handshake: cmd transfers on a cycle where cmd_valid & cmd_ready are both 1; eng_valid holds with a stable payload until eng_ready, a one-cycle done pulse.
interface tile_write_scheduler_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [63:0]  cmd_data;
  logic [63:0]  cmd_strobe;
  logic [15:0]  cmd_win;
  logic [255:0] cmd_area;
  logic         eng_valid;
  logic         eng_ready;
  logic [63:0]  eng_data;
  logic [63:0]  eng_strobe;
  logic [3:0]   eng_axlo;
  logic [3:0]   eng_axhi;
  logic [3:0]   eng_aylo;
  logic [3:0]   eng_ayhi;
  logic [255:0] eng_area_in;
  logic [255:0] eng_area_out;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_strobe, cmd_win, cmd_area,
    output cmd_ready,
    output eng_valid, eng_data, eng_strobe, eng_axlo, eng_axhi, eng_aylo, eng_ayhi, eng_area_in,
    input  eng_ready, eng_area_out
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_strobe, cmd_win, cmd_area,
    input  cmd_ready,
    input  eng_valid, eng_data, eng_strobe, eng_axlo, eng_axhi, eng_aylo, eng_ayhi, eng_area_in,
    output eng_ready, eng_area_out
  );
endinterface

// File: rtl/tile_write_scheduler.sv
// Buffers WRITE/LOAD/CLEAR/NOP commands and issues WRITEs one at a time to the tile engine,
// owning the committed 16x16 area, completion count and a stuck-engine watchdog.
module tile_write_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   resetn,
  tile_write_scheduler_if.slave  bus,
  output logic [255:0]           area,
  input  logic [3:0]             rd_row,
  output logic [15:0]            rd_row_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            cmd_count,
  output logic                   err_timeout,
  output logic                   dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
  state_t state, state_nx;

  logic [1:0]   q_op     [DEPTH];
  logic [63:0]  q_data   [DEPTH];
  logic [63:0]  q_strobe [DEPTH];
  logic [15:0]  q_win    [DEPTH];
  logic [255:0] q_area   [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, empty, push, pop;
  logic [63:0]   cur_data, cur_strobe;
  logic [15:0]   cur_win;
  logic [WW-1:0] wd_cnt;

  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);
  assign push  = bus.cmd_valid && !full;

  // The 256-bit payload is only meaningful for LOAD, so it is captured only then.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]     <= bus.cmd_op;
      q_data[wr_ptr]   <= bus.cmd_data;
      q_strobe[wr_ptr] <= bus.cmd_strobe;
      q_win[wr_ptr]    <= bus.cmd_win;
      if (bus.cmd_op == OP_LOAD) q_area[wr_ptr] <= bus.cmd_area;
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (q_op[rd_ptr] == OP_WRITE) state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.eng_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      cur_data    <= '0;
      cur_strobe  <= '0;
      cur_win     <= '0;
      area        <= '0;
      done        <= 1'b0;
      cmd_count   <= '0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;

      if (pop) begin
        cur_data   <= q_data[rd_ptr];
        cur_strobe <= q_strobe[rd_ptr];
        cur_win    <= q_win[rd_ptr];
        wd_cnt     <= '0;
        case (q_op[rd_ptr])
          OP_LOAD:  area <= q_area[rd_ptr];
          OP_CLEAR: area <= '0;
          default:  ;
        endcase
        // Everything except WRITE finishes at the pop edge itself.
        if (q_op[rd_ptr] != OP_WRITE) begin
          done      <= 1'b1;
          cmd_count <= cmd_count + 1'b1;
        end
      end

      if (state == S_RUN) begin
        if (bus.eng_ready) begin
          area      <= bus.eng_area_out;
          done      <= 1'b1;
          cmd_count <= cmd_count + 1'b1;
        end
        // Saturating count; the flag is sticky and the engine is never aborted.
        if (wd_cnt != WW'(TIMEOUT))     wd_cnt      <= wd_cnt + 1'b1;
        if (wd_cnt == WW'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.eng_valid   = (state == S_RUN);
  assign bus.eng_data    = cur_data;
  assign bus.eng_strobe  = cur_strobe;
  assign bus.eng_axlo    = cur_win[3:0];
  assign bus.eng_axhi    = cur_win[7:4];
  assign bus.eng_aylo    = cur_win[11:8];
  assign bus.eng_ayhi    = cur_win[15:12];
  assign bus.eng_area_in = area;

  assign busy        = !empty || (state != S_IDLE);
  assign rd_row_data = area[{rd_row, 4'b0000} +: 16];
  assign dbg_state   = state;
endmodule

// File: tb/tb_tile_write_scheduler.sv
// Bench for tile_write_scheduler: command driver, engine responder, and a scoreboard
// holding the expected committed area after each completion.
module tb_tile_write_scheduler;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic         clk;
  logic         resetn;
  logic [255:0] area;
  logic [3:0]   rd_row;
  logic [15:0]  rd_row_data;
  logic         busy, done, err_timeout, dbg_state;
  logic [15:0]  cmd_count;

  tile_write_scheduler_if bus();

  tile_write_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .area        (area),
    .rd_row      (rd_row),
    .rd_row_data (rd_row_data),
    .busy        (busy),
    .done        (done),
    .cmd_count   (cmd_count),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  int vec_count   = 0;
  int miscompares = 0;
  int done_seen   = 0;
  logic [15:0]  exp_count = '0;
  logic [255:0] model_area = '0;
  logic [255:0] exp_q[$];
  logic [255:0] exp_ain_q[$];
  logic [63:0]  exp_dat_q[$];

  bit eng_enable  = 1'b0;
  int eng_latency = 3;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] eng_fn(input logic [255:0] a, input logic [63:0] d,
                                          input logic [63:0] s, input logic [15:0] w);
    return a ^ {4{d & s}} ^ {240'd0, w};
  endfunction

  // engine responder
  initial begin
    int run_cyc;
    run_cyc = 0;
    bus.eng_ready    = 1'b0;
    bus.eng_area_out = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_ready = 1'b0;
      if (bus.eng_valid && resetn) run_cyc++;
      else run_cyc = 0;
      if (bus.eng_valid && eng_enable && run_cyc >= eng_latency) begin
        bus.eng_ready    = 1'b1;
        bus.eng_area_out = eng_fn(bus.eng_area_in, bus.eng_data, bus.eng_strobe,
                                  {bus.eng_ayhi, bus.eng_aylo, bus.eng_axhi, bus.eng_axlo});
        run_cyc = 0;
      end
    end
  end

  // monitor: issue payload, post-done valid gap, completion scoreboard
  initial begin
    logic prev_valid, prev_ready;
    logic [255:0] e;
    logic [63:0]  ed;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bus.eng_valid && !prev_valid) begin
          check_eq("eng_has_exp", exp_ain_q.size() != 0, 1);
          if (exp_ain_q.size() != 0) begin
            e  = exp_ain_q.pop_front();
            ed = exp_dat_q.pop_front();
            check_eq("eng_area_in", bus.eng_area_in, e);
            check_eq("eng_data", bus.eng_data, ed);
          end
        end
        if (prev_ready) check_eq("valid_gap", bus.eng_valid, 0);
        if (done) begin
          done_seen++;
          exp_count = exp_count + 1'b1;
          check_eq("done_has_exp", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("area_commit", area, e);
          end
          check_eq("cmd_count", cmd_count, exp_count);
        end
      end
      prev_valid = bus.eng_valid && resetn;
      prev_ready = bus.eng_valid && bus.eng_ready && resetn;
    end
  end

  // driver
  task automatic push_cmd(input logic [1:0] op, input logic [63:0] d, input logic [63:0] s,
                          input logic [15:0] w, input logic [255:0] a);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_data   = d;
    bus.cmd_strobe = s;
    bus.cmd_win    = w;
    bus.cmd_area   = a;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
        case (op)
          2'd0: begin
            exp_ain_q.push_back(model_area);
            exp_dat_q.push_back(d);
            model_area = eng_fn(model_area, d, s, w);
          end
          2'd1: model_area = a;
          2'd2: model_area = '0;
          default: ;
        endcase
        exp_q.push_back(model_area);
      end
    end
    #1;
    bus.cmd_valid = 1'b0;
    check_eq("push_accepted", ok, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    check_eq("idle_reached", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_ain_q.delete();
    exp_dat_q.delete();
    model_area = '0;
    exp_count  = '0;
  endtask

  initial begin
    int d0;
    bit seen;
    logic [63:0] rd, rs;
    logic [255:0] ra;

    // reset held with a command offered
    resetn         = 1'b0;
    rd_row         = 4'd0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 2'd0;
    bus.cmd_data   = 64'hDEAD;
    bus.cmd_strobe = '1;
    bus.cmd_win    = 16'hF0F0;
    bus.cmd_area   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_area", area, 0);
    check_eq("rst_cmd_count", cmd_count, 0);
    check_eq("rst_eng_valid", bus.eng_valid, 0);
    check_eq("rst_eng_data", bus.eng_data, 0);
    check_eq("rst_err", err_timeout, 0);
    bus.cmd_valid = 1'b0;
    resetn        = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_no_push", busy, 0);

    // single WRITE and issue latency
    eng_enable  = 1'b1;
    eng_latency = 3;
    d0 = done_seen;
    push_cmd(2'd0, 64'h0F, 64'hFF, 16'hF0F0, '0);
    check_eq("lat_n1_valid", bus.eng_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_n2_valid", bus.eng_valid, 1);
    check_eq("lat_strobe", bus.eng_strobe, 64'hFF);
    check_eq("lat_window", {bus.eng_ayhi, bus.eng_aylo, bus.eng_axhi, bus.eng_axlo}, 16'hF0F0);
    wait_idle(100);
    check_eq("single_done_cnt", done_seen - d0, 1);
    check_eq("single_count", cmd_count, 1);

    // full FIFO with engine held off
    eng_enable = 1'b0;
    d0 = done_seen;
    for (int i = 0; i < DEPTH + 1; i++)
      push_cmd(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 16'(i * 16'h1111), '0);
    check_eq("full_cmd_ready", bus.cmd_ready, 0);
    check_eq("full_busy", busy, 1);
    eng_latency = 5;
    eng_enable  = 1'b1;
    wait_idle(300);
    check_eq("full_done_cnt", done_seen - d0, DEPTH + 1);
    check_eq("full_cmd_ready_after", bus.cmd_ready, 1);

    // ordering: LOAD, WRITE, CLEAR
    eng_latency = 3;
    d0 = done_seen;
    push_cmd(2'd1, '0, '0, '0, '1);
    push_cmd(2'd0, 64'h1234_5678_9ABC_DEF0, '1, 16'hF0F0, '0);
    push_cmd(2'd2, '0, '0, '0, '0);
    wait_idle(100);
    check_eq("order_done_cnt", done_seen - d0, 3);
    check_eq("order_area", area, 0);

    // mixed random traffic, including an inverted window
    push_cmd(2'd1, '0, '0, '0, {8{$urandom}});
    push_cmd(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 16'h29E4, '0);
    for (int i = 0; i < 10; i++) begin
      eng_latency = $urandom_range(1, 4);
      rd = {$urandom, $urandom};
      rs = {$urandom, $urandom};
      ra = {8{$urandom}};
      push_cmd(2'($urandom_range(0, 3)), rd, rs, 16'($urandom), ra);
    end
    wait_idle(400);
    check_eq("mix_area", area, model_area);
    for (int r = 0; r < 16; r += 5) begin
      rd_row = 4'(r);
      #1;
      check_eq("rd_row_data", rd_row_data, model_area[r*16 +: 16]);
    end

    // watchdog
    check_eq("wd_pre_err", err_timeout, 0);
    eng_enable = 1'b0;
    push_cmd(2'd0, 64'h55, 64'hFF, 16'hF0F0, '0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.eng_valid) seen = 1'b1;
    end
    check_eq("wd_valid_rise", seen, 1);
    check_eq("wd_err_at_rise", err_timeout, 0);
    repeat (15) @(negedge clk);
    check_eq("wd_err_before", err_timeout, 0);
    @(negedge clk);
    check_eq("wd_err_set", err_timeout, 1);
    check_eq("wd_still_valid", bus.eng_valid, 1);

    // reset while RUN with two entries queued
    push_cmd(2'd0, 64'h1, 64'h1, 16'h0, '0);
    push_cmd(2'd1, '0, '0, '0, '1);
    check_eq("mid_busy", busy, 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_eng_valid", bus.eng_valid, 0);
    check_eq("mid_busy_rst", busy, 0);
    check_eq("mid_err", err_timeout, 0);
    check_eq("mid_cmd_ready", bus.cmd_ready, 1);
    check_eq("mid_area", area, 0);
    check_eq("mid_state", dbg_state, 0);
    flush_model();
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_fifo_empty", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
